data_wb: RTL

- Write-back stage of the pipelined ARM-subset CPU, sitting between the MEM stage and the register file inside data_id.
- Produces data_id's write-side inputs: WBsignal, BLT, BLsignal, RegWrite and the write address.
- Holds the MEM/WB pipeline register.
- Stalls the MEM stage while load data is outstanding from data memory.
- Counts retired instructions.

---
 rtl/data_wb.sv | 123 ++++++++++++
 1 files changed

// File: rtl/data_wb.sv
// Write-back stage: MEM/WB pipeline register, load-data wait with timeout,
// register-file write-side outputs and a retired-instruction counter.
module data_wb #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic             mem_RegWrite,
  input  logic             mem_MemtoReg,
  input  logic             mem_BLsignal,
  input  logic             mem_load,
  input  logic [4:0]       mem_Rd,
  input  logic [63:0]      mem_alu_result,
  input  logic [63:0]      mem_pc,
  input  logic             dmem_ack,
  input  logic [63:0]      dmem_rdata,
  output logic [63:0]      WBsignal,
  output logic [63:0]      BLT,
  output logic             BLsignal,
  output logic             RegWrite,
  output logic [4:0]       Rd,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {StEmpty, StValid, StWait} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        rw_q, m2r_q, bl_q;
  logic [63:0] alu_q;
  logic        capture, ack_take, timeout;

  assign capture  = mem_valid & mem_ready;
  assign ack_take = (state_q == StWait) & dmem_ack;
  // An ack on the final wait cycle takes priority over the timeout.
  assign timeout  = (state_q == StWait) & ~dmem_ack & ((cnt_q + 8'd1) == 8'(TIMEOUT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty, StValid: begin
        if (capture) begin
          state_d = mem_load ? StWait : StValid;
        end else begin
          state_d = StEmpty;
        end
      end
      StWait: begin
        if (ack_take) begin
          state_d = StValid;
        end else if (timeout) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    mem_ready = reset_n & (state_q != StWait);
    RegWrite  = 1'b0;
    BLsignal  = 1'b0;
    if (state_q == StValid) begin
      // Writes to XZR are dropped unless this is a link write.
      RegWrite = rw_q & ((Rd != 5'd31) | bl_q);
      BLsignal = bl_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rw_q     <= 1'b0;
      m2r_q    <= 1'b0;
      bl_q     <= 1'b0;
      alu_q    <= '0;
      WBsignal <= '0;
      BLT      <= '0;
      Rd       <= '0;
      cnt_q    <= '0;
      mem_err  <= 1'b0;
      retired  <= '0;
    end else begin
      if (capture) begin
        rw_q  <= mem_RegWrite;
        m2r_q <= mem_MemtoReg;
        bl_q  <= mem_BLsignal;
        alu_q <= mem_alu_result;
        BLT   <= mem_pc + 64'd4;
        Rd    <= mem_BLsignal ? 5'd30 : mem_Rd;
        if (!mem_load) begin
          WBsignal <= mem_alu_result;
        end
      end
      if (ack_take) begin
        WBsignal <= m2r_q ? dmem_rdata : alu_q;
      end
      if (state_q == StWait) begin
        cnt_q <= (ack_take || timeout) ? 8'd0 : cnt_q + 8'd1;
      end else begin
        cnt_q <= 8'd0;
      end
      if (timeout) begin
        mem_err <= 1'b1;
      end
      if (state_q == StValid) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

endmodule
